regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the CPU datapath: one synchronous write port, `NUM_RD` combinational read ports, optional hardwired-zero register 0, and a sequenced soft-clear engine that zeroes the array one entry per cycle without asserting the global reset. It is the successor to the fixed 32×32, two-read-port register file. It sits between instruction decode (read addresses) and write-back (write port).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_seq.sv | 56 +++++
 rtl/regfile_mp.sv | 91 +++++++++
 tb/tb_regfile_mp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state type for the multi-port register file.
package regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NUM_RD = 2;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks clr_idx from 0 to DEPTH-1, one entry per cycle.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
   parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clr,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      case (state_q)
         RF_IDLE: begin
            if (clr) begin
               state_d   = RF_SWEEP;
               clr_idx_d = '0;
            end
         end
         RF_SWEEP: begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == LAST_IDX) begin
               state_d   = RF_IDLE;
               clr_idx_d = '0;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= RF_IDLE;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   assign busy     = (state_q == RF_SWEEP);
   assign clr_we   = busy;
   assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired-zero R0 and sequenced soft clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
   parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
   parameter int unsigned DEPTH    = 2 ** ADDR_W,
   parameter int unsigned NUM_RD   = regfile_pkg::NUM_RD,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
   output logic [NUM_RD*DATA_W-1:0] R_Data,
   input  logic [ADDR_W-1:0]        W_Addr,
   input  logic [DATA_W-1:0]        W_Data,
   input  logic                     Write_Reg,
   output logic                     W_Ready,
   input  logic                     Clr,
   output logic                     Busy
);

   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              w_ok_c;

   regfile_clr_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clr_seq (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (Clr),
      .busy     (Busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign W_Ready = !Busy;

   // Accepted write: port ready, address in range, not the hardwired zero register.
   assign w_ok_c = Write_Reg && W_Ready && ({1'b0, W_Addr} < DEPTH_EXT) &&
                   !((ZERO_REG != 0) && (W_Addr == '0));

   // Clear writes only occur while W_Ready is low, so they never collide with a port write.
   always_comb begin
      mem_d = mem_q;
      if (clr_we) begin
         mem_d[clr_addr] = '0;
      end else if (w_ok_c) begin
         mem_d[W_Addr] = W_Data;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_c;

      assign ra = R_Addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd_c = '0;
         if (({1'b0, ra} < DEPTH_EXT) && !((ZERO_REG != 0) && (ra == '0))) begin
            rd_c = mem_q[ra];
         end
`ifdef REGFILE_BYPASS_EN
         if (w_ok_c && (ra == W_Addr)) begin
            rd_c = W_Data;
         end
`endif
      end

      assign R_Data[k*DATA_W +: DATA_W] = rd_c;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed checks plus randomized traffic against a behavioural model,
// on a default instance (32 regs, 2 ports) and a 24-deep, 4-port instance.
module tb_regfile_mp;

   logic        Clk;
   logic        Reset;

   logic        wr  [2];
   logic [4:0]  wa  [2];
   logic [31:0] wd  [2];
   logic        clr [2];
   logic [4:0]  ra  [2][4];

   logic [9:0]   r_addr1;
   logic [19:0]  r_addr2;
   logic [63:0]  rd1;
   logic [127:0] rd2;
   logic         busy1, busy2, wrdy1, wrdy2;

   int checks = 0;
   int errors = 0;

   // Model: register contents plus a queue of entries still waiting to be swept.
   logic [31:0] m [2][32];
   int          sq [2][$];
   int          dep [2] = '{32, 24};
   int          nrd [2] = '{2, 4};

   assign r_addr1 = {ra[0][1], ra[0][0]};
   assign r_addr2 = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};

   regfile_mp u_dut1 (
      .Clk       (Clk),
      .Reset     (Reset),
      .R_Addr    (r_addr1),
      .R_Data    (rd1),
      .W_Addr    (wa[0]),
      .W_Data    (wd[0]),
      .Write_Reg (wr[0]),
      .W_Ready   (wrdy1),
      .Clr       (clr[0]),
      .Busy      (busy1)
   );

   regfile_mp #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .DEPTH    (24),
      .NUM_RD   (4),
      .ZERO_REG (1)
   ) u_dut2 (
      .Clk       (Clk),
      .Reset     (Reset),
      .R_Addr    (r_addr2),
      .R_Data    (rd2),
      .W_Addr    (wa[1]),
      .W_Data    (wd[1]),
      .Write_Reg (wr[1]),
      .W_Ready   (wrdy2),
      .Clr       (clr[1]),
      .Busy      (busy2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane(input int i, input int k);
      if (i == 0) return rd1[k*32 +: 32];
      return rd2[k*32 +: 32];
   endfunction

   function automatic logic dut_busy(input int i);
      return (i == 0) ? busy1 : busy2;
   endfunction

   function automatic logic dut_wrdy(input int i);
      return (i == 0) ? wrdy1 : wrdy2;
   endfunction

   function automatic logic wr_legal(input int i);
      return wr[i] && (sq[i].size() == 0) && (int'(wa[i]) < dep[i]) && (wa[i] != 5'd0);
   endfunction

   function automatic logic [31:0] exp_rd(input int i, input int a);
      logic [31:0] v;
      v = '0;
      if (a < dep[i] && a != 0) v = m[i][a];
`ifdef REGFILE_BYPASS_EN
      if (wr_legal(i) && int'(wa[i]) == a) v = wd[i];
`endif
      return v;
   endfunction

   // Model update on each clock edge; reset wipes everything.
   always @(posedge Clk or posedge Reset) begin
      for (int i = 0; i < 2; i++) begin
         if (Reset) begin
            for (int a = 0; a < 32; a++) m[i][a] = '0;
            sq[i].delete();
         end else if (sq[i].size() != 0) begin
            m[i][sq[i].pop_front()] = '0;
         end else begin
            if (wr_legal(i)) m[i][wa[i]] = wd[i];
            if (clr[i]) for (int a = 0; a < dep[i]; a++) sq[i].push_back(a);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d_busy", i), 32'(dut_busy(i)), 32'(sq[i].size() != 0));
         chk($sformatf("u%0d_wready", i), 32'(dut_wrdy(i)), 32'(sq[i].size() == 0));
         for (int k = 0; k < nrd[i]; k++)
            chk($sformatf("u%0d_rd%0d", i, k), lane(i, k), exp_rd(i, int'(ra[i][k])));
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         wr[i]  = 1'b0;
         clr[i] = 1'b0;
      end
   endtask

   int busy_cnt;

   initial begin
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr[i] = 1'b0; wa[i] = '0; wd[i] = '0; clr[i] = 1'b0;
         for (int k = 0; k < 4; k++) ra[i][k] = 5'(k + 5);
      end
      #12;
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_wready", 32'(wrdy1), 32'd1);
      chk("rst_rd0", rd1[31:0], 32'd0);
      chk("rst_rd1", rd1[63:32], 32'd0);
      Reset = 1'b0;
      tick();

      // Write R5 and read it back, then an asynchronous mid-cycle reset.
      wr[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0][0] = 5'd5;
      tick();
      wr[0] = 1'b0;
      chk("r5_readback", rd1[31:0], 32'hDEADBEEF);
      #2 Reset = 1'b1;
      #1 chk("async_rst_rd0", rd1[31:0], 32'd0);
      #3 Reset = 1'b0;
      tick();

      // Hardwired zero register and top register on both ports.
      wr[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234;
      tick();
      wa[0] = 5'd31;
      tick();
      wr[0] = 1'b0; ra[0][0] = 5'd0; ra[0][1] = 5'd31;
      #1 chk("r0_zero", rd1[31:0], 32'd0);
      ra[0][0] = 5'd31;
      #1 chk("r31_port0", rd1[31:0], 32'h1234);
      chk("r31_port1", rd1[63:32], 32'h1234);

      // Fill with index values, then sweep.
      for (int a = 0; a < 32; a++) begin
         wr[0] = 1'b1; wa[0] = 5'(a); wd[0] = 32'(a);
         tick();
      end
      wr[0] = 1'b0;
      ra[0][0] = 5'd3; ra[0][1] = 5'd20;
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 40 && busy1; c++) begin
         if (c == 10) begin
            chk("sweep_r3_cleared", rd1[31:0], 32'd0);
            chk("sweep_r20_kept", rd1[63:32], 32'd20);
         end
         wr[0] = (c == 12); wa[0] = 5'd7; wd[0] = 32'h77;
         busy_cnt++;
         tick();
      end
      wr[0] = 1'b0;
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
      ra[0][0] = 5'd7;
      #1 chk("sweep_r7_dropped", rd1[31:0], 32'd0);

      // Same-cycle write/read of R9.
      wr[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h11;
      tick();
      wd[0] = 32'hA5A5A5A5; ra[0][0] = 5'd9;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same_cycle", rd1[31:0], 32'hA5A5A5A5);
`else
      chk("nobypass_same_cycle", rd1[31:0], 32'h11);
`endif
      tick();
      wr[0] = 1'b0;
      #1 chk("r9_after_edge", rd1[31:0], 32'hA5A5A5A5);

      // 24-deep, 4-port instance: out-of-range accesses and distinct reads.
      wr[1] = 1'b1; wa[1] = 5'd26; wd[1] = 32'hBAD0BAD0;
      tick();
      wa[1] = 5'd1;  wd[1] = 32'h1111; tick();
      wa[1] = 5'd2;  wd[1] = 32'h2222; tick();
      wa[1] = 5'd5;  wd[1] = 32'h5555; tick();
      wa[1] = 5'd23; wd[1] = 32'h2323; tick();
      wr[1] = 1'b0;
      ra[1][0] = 5'd30; ra[1][1] = 5'd26;
      #1 chk("p4_rd_addr30", rd2[31:0], 32'd0);
      chk("p4_wr26_dropped", rd2[63:32], 32'd0);
      ra[1][0] = 5'd23; ra[1][1] = 5'd5; ra[1][2] = 5'd2; ra[1][3] = 5'd1;
      #1 chk("p4_port0", rd2[31:0], 32'h2323);
      chk("p4_port1", rd2[63:32], 32'h5555);
      chk("p4_port2", rd2[95:64], 32'h2222);
      chk("p4_port3", rd2[127:96], 32'h1111);

      // Reset mid-sweep, then a fresh sweep restarts at index 0.
      clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      repeat (4) tick();
      #2 Reset = 1'b1;
      #1 chk("midsweep_rst_busy", 32'(busy1), 32'd0);
      #3 Reset = 1'b0;
      tick();
      wr[0] = 1'b1; wa[0] = 5'd1; wd[0] = 32'h55; tick();
      wa[0] = 5'd10; wd[0] = 32'h66; tick();
      wr[0] = 1'b0; clr[0] = 1'b1; tick(); clr[0] = 1'b0;
      ra[0][0] = 5'd1; ra[0][1] = 5'd10;
      repeat (2) tick();
      chk("restart_r1_cleared", rd1[31:0], 32'd0);
      chk("restart_r10_kept", rd1[63:32], 32'h66);
      repeat (40) tick();

      // Randomized traffic on both instances, checked every cycle by the compare process.
      for (int n = 0; n < 3000; n++) begin
         Reset = ($urandom_range(0, 399) == 0);
         for (int i = 0; i < 2; i++) begin
            wr[i]  = 1'($urandom_range(0, 1));
            wa[i]  = 5'($urandom_range(0, 31));
            wd[i]  = $urandom;
            clr[i] = ($urandom_range(0, 79) == 0);
            for (int k = 0; k < 4; k++)
               ra[i][k] = ($urandom_range(0, 3) == 0) ? wa[i] : 5'($urandom_range(0, 31));
         end
         tick();
      end
      Reset = 1'b0;
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
